// File: rtl/row_skew_pkg.sv
// Shared types and default geometry for the row_skew block (L0 -> MAC west-edge skew).
package row_skew_pkg;

  localparam int ROW = 8;
  localparam int BW  = 4;
  localparam int LAT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/row_skew_skew_line.sv
// Depth-N register chain carrying one row word plus its valid bit; N=0 is a wire.
module skew_line #(
  parameter int N  = 0,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] d,
  input  logic          v,
  output logic [BW-1:0] q,
  output logic          qv
);

  generate
    if (N == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q  = d;
      assign qv = v;
    end else begin : g_chain
      logic [N-1:0][BW-1:0] dat;
      logic [N-1:0]         vld;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dat <= '0;
          vld <= '0;
        end else begin
          dat[0] <= d;
          vld[0] <= v;
          for (int k = 1; k < N; k++) begin
            dat[k] <= dat[k-1];
            vld[k] <= vld[k-1];
          end
        end
      end

      assign q  = dat[N-1];
      assign qv = vld[N-1];
    end
  endgenerate

endmodule

// File: rtl/row_skew.sv
// Reads len vectors from L0 and re-times them into a diagonal wavefront (row i delayed i cycles).
// Optional ROW_SKEW_ZERO_FILL_EN forces out rows to zero outside their valid cycles.
module row_skew #(
  parameter int row   = row_skew_pkg::ROW,
  parameter int bw    = row_skew_pkg::BW,
  parameter int LAT   = row_skew_pkg::LAT,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 l0_rd,
  input  logic [row*bw-1:0]    in,
  output logic [row*bw-1:0]    out,
  output logic [row-1:0]       out_valid,
  output logic                 busy,
  output logic                 done
);
  import row_skew_pkg::*;

  localparam int DW = $clog2(LAT + row + 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_STREAM = STREAM;
  localparam logic [1:0] S_DRAIN  = DRAIN;

  logic [1:0]       state;
  logic [LEN_W-1:0] rd_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [LAT:1]     vld_pipe;
  logic             cap_valid;
  logic             cap_vld;

  logic [row-1:0][bw-1:0] in_w, cap_data, out_w;

  // drain_cnt covers LAT return cycles plus the deepest skew line; done lands on IDLE entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state  <= S_STREAM;
              rd_cnt <= len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          rd_cnt <= rd_cnt - 1'b1;
          if (rd_cnt == LEN_W'(1)) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(LAT + row);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DW'(1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign l0_rd = (state == S_STREAM);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= l0_rd;
      for (int k = 2; k <= LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign cap_valid = vld_pipe[LAT];
  assign in_w      = in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld  <= 1'b0;
      cap_data <= '0;
    end else begin
      cap_vld <= cap_valid;
      if (cap_valid) cap_data <= in_w;
    end
  end

  generate
    for (genvar i = 0; i < row; i++) begin : g_row
      logic [bw-1:0] q;
      logic          qv;

      skew_line #(.N(i), .BW(bw)) u_line (
        .clk   (clk),
        .reset (reset),
        .d     (cap_data[i]),
        .v     (cap_vld),
        .q     (q),
        .qv    (qv)
      );

`ifdef ROW_SKEW_ZERO_FILL_EN
      assign out_w[i] = qv ? q : '0;
`else
      assign out_w[i] = q;
`endif
      assign out_valid[i] = qv;
    end
  endgenerate

  assign out = out_w;

endmodule

// File: tb/tb_row_skew.sv
// Self-checking bench for row_skew: timing-rule model plus directed scenarios.
module tb_row_skew;
  localparam int ROW = 8, BW = 4, LAT = 2, LEN_W = 8, NC = 1024;
`ifdef ROW_SKEW_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                 clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [LEN_W-1:0]     len = '0;
  logic                 l0_rd, busy, done;
  logic [ROW*BW-1:0]    in_bus = '0, out;
  logic [ROW-1:0]       out_valid;

  always #5 clk = ~clk;

  row_skew #(.row(ROW), .bw(BW), .LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .l0_rd(l0_rd),
    .in(in_bus), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  int cyc = 0, n_chk = 0, n_fail = 0;
  event tick;

  bit              exp_rd[NC], exp_busy[NC], exp_done[NC];
  bit [ROW-1:0]    exp_vld[NC];
  bit [ROW*BW-1:0] exp_dat[NC];
  bit [ROW*BW-1:0] in_sched[NC];
  bit [ROW*BW-1:0] hold, eo;
  int model_req = 0, l0_idx = 0, rd_total = 0, last_done = 0;
  int done_q[$];
  int t, r0, d0;

  function automatic bit [ROW*BW-1:0] word(int k);
    return (k < 4) ? 32'h76543210 : 32'(k) * 32'h9E3779B1;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected behaviour of one accepted command, from the documented cycle rules
  function automatic void model_start(int ts, int l);
    bit [ROW*BW-1:0] w;
    int dc;
    if (ts < last_done) return;
    for (int j = 1; j <= l; j++) begin
      w = word(model_req);
      model_req++;
      exp_rd[ts+j] = 1'b1;
      for (int i = 0; i < ROW; i++) begin
        exp_vld[ts+j+LAT+1+i][i] = 1'b1;
        exp_dat[ts+j+LAT+1+i][i*BW +: BW] = w[i*BW +: BW];
      end
    end
    dc = (l == 0) ? ts + 1 : ts + l + LAT + ROW + 1;
    for (int k = ts + 1; k < dc; k++) exp_busy[k] = 1'b1;
    exp_done[dc] = 1'b1;
    last_done = dc;
  endfunction

  function automatic void model_reset(int n);
    for (int k = n; k < NC; k++) begin
      exp_rd[k] = 0; exp_busy[k] = 0; exp_done[k] = 0; exp_vld[k] = '0; exp_dat[k] = '0;
    end
    hold = '0;
    last_done = n;
    l0_idx = model_req;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    in_bus = in_sched[cyc];
    -> tick;
  end

  // L0 responder plus per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (l0_rd === 1'b1) begin
      rd_total++;
      in_sched[cyc+LAT] = word(l0_idx);
      l0_idx++;
    end
    if (done === 1'b1) done_q.push_back(cyc);
    eo = '0;
    for (int i = 0; i < ROW; i++) begin
      if (exp_vld[cyc][i]) begin
        hold[i*BW +: BW] = exp_dat[cyc][i*BW +: BW];
        eo[i*BW +: BW] = hold[i*BW +: BW];
      end else begin
        eo[i*BW +: BW] = ZF ? '0 : hold[i*BW +: BW];
      end
    end
    chk($sformatf("l0_rd@%0d", cyc), l0_rd, exp_rd[cyc]);
    chk($sformatf("busy@%0d", cyc), busy, exp_busy[cyc]);
    chk($sformatf("done@%0d", cyc), done, exp_done[cyc]);
    chk($sformatf("out_valid@%0d", cyc), out_valid, exp_vld[cyc]);
    chk($sformatf("out@%0d", cyc), out, eo);
  end

  task automatic issue(int l);
    start = 1'b1;
    len = LEN_W'(l);
    model_start(cyc, l);
    @(tick);
    start = 1'b0;
    len = '0;
  endtask

  task automatic wait_to(int n);
    while (cyc < n) @(tick);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(tick);
    #2;
    chk("rst_l0_rd", l0_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    reset = 1'b1;
    @(tick);

    // len=4 with constant word: diagonal of nibbles 0..7, done at t+15
    t = cyc; r0 = rd_total;
    issue(4);
    wait_to(t + 4);  #2;
    chk("t1_row0_vld", out_valid[0], 1);
    chk("t1_row0_dat", out[3:0], 4'h0);
    wait_to(t + 11); #2;
    chk("t1_row7_vld", out_valid[7], 1);
    chk("t1_row7_dat", out[31:28], 4'h7);
    wait_to(t + 15); #2;
    chk("t1_done_t15", done, 1);
    chk("t1_busy_t15", busy, 0);
    chk("t1_reads", rd_total - r0, 4);
    wait_to(t + 20); #2;
    chk("t1_idle_out", out, ZF ? 32'h0 : 32'h76543210);
    chk("t1_idle_vld", out_valid, 0);

    // len=0: immediate done, no reads
    @(tick);
    t = cyc; r0 = rd_total;
    issue(0);
    wait_to(t + 1); #2;
    chk("t2_done_t1", done, 1);
    wait_to(t + 5);
    chk("t2_reads", rd_total - r0, 0);

    // start while busy is dropped
    t = cyc; r0 = rd_total; d0 = done_q.size();
    issue(3);
    wait_to(t + 2);
    issue(9);
    wait_to(t + 3 + LAT + ROW + 6);
    chk("t3_reads", rd_total - r0, 3);
    chk("t3_dones", done_q.size() - d0, 1);
    chk("t3_done_cyc", done_q[$] - t, 14);

    // back-to-back: second start in the done cycle
    t = cyc; r0 = rd_total; d0 = done_q.size();
    issue(2);
    wait_to(t + 13);
    issue(2);
    wait_to(t + 30);
    chk("t4_reads", rd_total - r0, 4);
    chk("t4_dones", done_q.size() - d0, 2);
    chk("t4_done_gap", done_q[$] - done_q[$-1], 13);

    // reset in STREAM cycle 3, then a fresh command
    t = cyc;
    issue(10);
    wait_to(t + 3);
    reset = 1'b0;
    model_reset(cyc);
    #1;
    chk("t5_rst_l0_rd", l0_rd, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_vld", out_valid, 0);
    chk("t5_rst_done", done, 0);
    repeat (3) @(tick);
    #2 reset = 1'b1;
    @(tick);
    t = cyc; r0 = rd_total;
    issue(3);
    wait_to(t + 3 + LAT + ROW + 1); #2;
    chk("t5_done_after_rst", done, 1);
    chk("t5_reads", rd_total - r0, 3);
    wait_to(cyc + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/row_skew.md
# row_skew

Downstream stage of the L0 row buffer. Issues read strobes to L0 for a commanded number of vectors and captures the parallel row words that come back. It re-times the words into the diagonal wavefront the MAC array's west edge expects: row i is delayed by i cycles. It reports per-row valids and a done pulse when the last row has drained.

## Interface
- row, 8, number of rows (MAC array height; matches L0 row count)
- bw, 4, bits per row word
- LAT, 2, fixed cycles from l0_rd high to data present on in (1 for L0's registered rd_en, 1 for the FIFO read)
- LEN_W, 8, width of the len command field

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state when 0
- start  input  1  single-cycle command pulse; sampled only in IDLE
- len  input  LEN_W  number of vectors to stream, sampled with start
- l0_rd  output  1  read strobe to L0
- in  input  row*bw  parallel row words from L0; row i at [bw*(i+1)-1:bw*i]
- out  output  row*bw  skewed row words to the MAC array west edge
- out_valid  output  row  per-row valid; bit i qualifies out row i
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last valid of row row-1

## Operation
- Reset values: l0_rd=0, out=0, out_valid=0, busy=0, done=0. State is IDLE, all counters and pipelines are 0.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: start=1 with len>0 goes to STREAM and loads rd_cnt=len. start=1 with len=0 goes straight to DRAIN's exit, so done pulses the next cycle and l0_rd never rises.
  - STREAM: l0_rd=1 every cycle and rd_cnt decrements. When rd_cnt reaches 1, the next state is DRAIN and drain_cnt is loaded with LAT+row.
  - DRAIN: l0_rd=0 and drain_cnt decrements. At 0, go to IDLE and assert done for exactly one cycle, aligned with the IDLE entry.
- start while busy is ignored and not queued.
- Capture path:
  - A LAT-deep valid shift register is fed by l0_rd.
  - Its tail is cap_valid. When cap_valid=1, in is captured into the stage-0 register of every row.
- Skew path:
  - Row i passes through a delay line of i additional stages, so row 0 has 1 stage in total.
  - A valid bit travels with each row's data.
  - out row i is the last stage of that row's delay line. out_valid[i] is that stage's valid bit.
- Rows never reorder; words within a row stay in request order.
- Widths: rd_cnt is LEN_W bits. drain_cnt is $clog2(LAT+row+1) bits. No arithmetic is applied to data.

## Timing
- start sampled high at edge t: l0_rd is high in cycles t+1 through t+len.
- A word requested in cycle c is on in during cycle c+LAT and captured at that cycle's end.
- out row i for that word is valid in cycle c+LAT+1+i.
- Row 0 of the first word is valid in cycle t+1+LAT+1. Row row-1 of the last word is valid in cycle t+len+LAT+row.
- done is high in cycle t+len+LAT+row+1; busy drops in the same cycle.
- Back-to-back: a start in the done cycle is accepted; no bubble is required.
- Reset low mid-stream: all outputs return to reset values immediately. In-flight words are discarded, and L0 contents are the caller's concern.

## Configuration
- ROW_SKEW_ZERO_FILL_EN defined: out row i is forced to 0 whenever out_valid[i]=0, so the array sees zeros outside the wavefront.
- Not defined: out row i holds the last value in its final stage, which saves the row*bw AND gates. Downstream logic must qualify data with out_valid.

## Structure
- Shared package holds the FSM state enum (IDLE, STREAM, DRAIN) and the default constants ROW=8, BW=4, LAT=2.
- One sub-module, skew_line: a parameterised depth-N register chain of bw data bits plus 1 valid bit, with async active-low reset. It is instantiated once per row with N=i. N=0 is a pass-through.
- The top level holds the FSM, counters, LAT valid pipe and capture register.

## Test plan
- Reset, then start with len=4. Check l0_rd is high exactly 4 cycles. With in=0x76543210 each returned cycle, out row i shows nibble i on its diagonal. done is high at t+4+2+8+1 = t+15.
- start with len=0: no l0_rd, done pulses at t+1, out_valid stays 0.
- start while busy (len=3, second start at t+2 with len=9): the second is ignored. Exactly 3 reads occur and there is one done.
- Two commands back-to-back (len=2, then start in the done cycle with len=2): 4 total reads, two done pulses 13 cycles apart. No row mixes data between the two commands.
- Reset asserted low in STREAM cycle 3 of len=10: l0_rd, out_valid, busy and done go to 0 immediately. After release, the FSM is in IDLE and accepts a new start.
- With ROW_SKEW_ZERO_FILL_EN, out is 0 wherever out_valid is 0 during the len=4 run. Without it, out retains the last captured nibble per row.
